// File: rtl/sseg_scan_hex.sv
// Time-multiplexed common-anode hex display driver: refresh prescaler, frame-synchronous
// input capture, per-digit blanking, decimal points and leading-zero suppression.
module sseg_scan_hex #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [4*NDIG-1:0]    x,
  input  logic [NDIG-1:0]      dp_in,
  input  logic [NDIG-1:0]      blank,
  input  logic                 lzb,
  input  logic                 en,
  output logic [NDIG-1:0]      an,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic                 frame
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic              r_primed;
  logic [4*NDIG-1:0] r_x_s;
  logic [NDIG-1:0]   r_dp_s;
  logic [NDIG-1:0]   r_blank_s;
  logic              r_lzb_s;
  logic [NDIG-1:0]   r_an;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic              r_frame;

  logic              w_tick;
  logic              w_load;
  logic [NDIG-1:0]   w_lz_dark;
  logic [3:0]        w_nib;
  logic              w_dark;
  logic              w_dp_sel;
  logic [6:0]        w_seg_dec;

  assign w_tick = en && (r_cnt == CNT_MAX);
  assign w_load = !r_primed || (w_tick && (r_idx == IDX_MAX));

  // A digit is LZ-dark when it and every more-significant shadow nibble is zero; digit 0 never is.
  always_comb begin
    logic w_zacc;
    w_lz_dark = '0;
    w_zacc    = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      w_zacc       = w_zacc && (r_x_s[4*i +: 4] == 4'h0);
      w_lz_dark[i] = r_lzb_s && w_zacc;
    end
  end

  assign w_nib    = 4'(r_x_s >> {r_idx, 2'b00});
  assign w_dp_sel = 1'(r_dp_s >> r_idx);
  assign w_dark   = 1'(r_blank_s >> r_idx) || 1'(w_lz_dark >> r_idx);

  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nib)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      4'hF: w_seg_dec = 7'h0E;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  // Prescaler and digit index; both hold while en is low.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (en) begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
    end
  end

  // Shadow capture at frame boundaries so a frame never mixes old and new values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_primed  <= 1'b0;
      r_x_s     <= '0;
      r_dp_s    <= '0;
      r_blank_s <= '0;
      r_lzb_s   <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_frame <= w_load;
      if (w_load) begin
        r_primed  <= 1'b1;
        r_x_s     <= x;
        r_dp_s    <= dp_in;
        r_blank_s <= blank;
        r_lzb_s   <= lzb;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (!en || w_dark) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(NDIG'(1) << r_idx);
      r_seg <= w_seg_dec;
      r_dp  <= ~w_dp_sel;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign dp    = r_dp;
  assign frame = r_frame;

endmodule

// File: tb/tb_sseg_scan_hex.sv
// Randomised bench for sseg_scan_hex with a behavioural display model (NDIG=4, PRESCALE=4).
module tb_sseg_scan_hex;

  localparam int N = 4;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic [15:0]   x;
  logic [3:0]    dp_in;
  logic [3:0]    blank;
  logic          lzb;
  logic          en;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame;

  sseg_scan_hex #(.NDIG(N), .PRESCALE(P)) dut (
    .clk(clk), .clr(clr), .x(x), .dp_in(dp_in), .blank(blank), .lzb(lzb), .en(en),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: what the display should be doing, in plain terms
  int          m_cnt, m_idx;
  bit          m_primed;
  logic [15:0] m_xs;
  logic [3:0]  m_dps, m_blanks;
  bit          m_lzbs;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_primed = 0;
    m_xs = '0; m_dps = '0; m_blanks = '0; m_lzbs = 0;
  endtask

  // Predict the outputs the coming edge will register, advance the model, then clock.
  task automatic step();
    bit tick, load, dark;
    logic [3:0] nib;
    tick = en && (m_cnt == P - 1);
    load = !m_primed || (tick && m_idx == N - 1);
    dark = m_blanks[m_idx] || (m_idx >= 1 && m_lzbs && ((m_xs >> (4 * m_idx)) == 16'h0));
    if (!en || dark) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << m_idx);
      nib   = m_xs[4*m_idx +: 4];
      e_seg = dec[nib];
      e_dp  = ~m_dps[m_idx];
    end
    e_frame = load;
    if (load) begin
      m_xs = x; m_dps = dp_in; m_blanks = blank; m_lzbs = lzb; m_primed = 1;
    end
    if (en) begin
      m_cnt = tick ? 0 : m_cnt + 1;
      if (tick) m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b1; x = 16'h1234; dp_in = '0; blank = '0; lzb = 1'b0;
    #1;
    n_checks++;
    if ({an, seg, dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_init an=%h seg=%h dp=%b fr=%b want F 7F 1 0", an, seg, dp, frame);
    end
    @(posedge clk);
    #2 clr = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
        n_errors++;
        $display("FAIL reset_run got %h %h %b %b want %h %h %b %b", an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
      end
    end
    // Mid-scan clear must darken outputs without a clock edge
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if ({an, seg, dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_async an=%h seg=%h dp=%b fr=%b want F 7F 1 0", an, seg, dp, frame);
    end
    #1 clr = 1'b0;
    model_reset();
  endtask

  task automatic test_scan();
    int frames = 0;
    x = 16'h12AF; lzb = 1'b0; blank = '0; dp_in = '0; en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 32; i++) begin
      step();
      if (frame === 1'b1) frames++;
      n_checks++;
      if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
        n_errors++;
        $display("FAIL scan got %h %h %b %b want %h %h %b %b", an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
      end
    end
    n_checks++;
    if (frames != 2) begin
      n_errors++;
      $display("FAIL scan_frames got %0d want 2", frames);
    end
  endtask

  task automatic test_tearing();
    int guard = 0;
    x = 16'h1234;
    while (!(m_primed && m_xs == 16'h1234 && m_idx == 2) && guard < 60) begin
      step(); guard++;
    end
    n_checks++;
    if (guard >= 60) begin
      n_errors++;
      $display("FAIL tear_sync timeout got %0d cycles want <60", guard);
    end
    x = 16'hBEEF;
    for (int i = 0; i < 28; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
        n_errors++;
        $display("FAIL tearing got %h %h %b %b want %h %h %b %b", an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
      end
    end
  endtask

  task automatic test_lzb();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    for (int v = 0; v < 2; v++) begin
      x = vals[v]; lzb = 1'b1;
      for (int i = 0; i < 36; i++) begin
        step();
        n_checks++;
        if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
          n_errors++;
          $display("FAIL lzb x=%h got %h %h %b %b want %h %h %b %b", x, an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
        end
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_blank_dp();
    x = 16'h8421; blank = 4'b0100; dp_in = 4'b0010;
    for (int i = 0; i < 36; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
        n_errors++;
        $display("FAIL blank_dp got %h %h %b %b want %h %h %b %b", an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
      end
    end
    blank = '0; dp_in = '0;
  endtask

  task automatic test_enable();
    int guard = 0;
    int frames = 0;
    x = 16'h5A3C;
    while (m_cnt != 1 && guard < 10) begin
      step(); guard++;
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (frame === 1'b1) frames++;
      n_checks++;
      if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
        n_errors++;
        $display("FAIL enable_off got %h %h %b %b want %h %h %b %b", an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
      end
    end
    n_checks++;
    if (frames != 0) begin
      n_errors++;
      $display("FAIL enable_frames got %0d want 0", frames);
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
        n_errors++;
        $display("FAIL enable_on got %h %h %b %b want %h %h %b %b", an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      x     = 16'($urandom);
      if ($urandom_range(0, 3) == 0) x = x & 16'h00FF;
      dp_in = 4'($urandom);
      blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      lzb   = 1'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      step();
      n_checks++;
      if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
        n_errors++;
        $display("FAIL random got %h %h %b %b want %h %h %b %b", an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
      end
      n_checks++;
      if ($countones(~an) > 1) begin
        n_errors++;
        $display("FAIL onehot an=%h want at most one low bit", an);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearing();
    test_lzb();
    test_blank_dp();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
